// File: rtl/chunked_addsub.sv
// chunked_addsub: multi-cycle adder/subtractor that processes CHUNK bits per clock.
// It starts with the least significant chunk, and the carry between chunks is registered.
//
// Parameters:
//   WIDTH  operand/result width in bits
//   CHUNK  bits summed per cycle; WIDTH must be a multiple of CHUNK
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request; accepted in IDLE or DONE
//   sub    0 = a+b, 1 = a-b (sampled with start)
//   a, b   operands (sampled with start)
//   busy   high while chunks are being processed (RUN)
//   done   one-cycle pulse when s/cout/ovf are updated
//   s      registered result, held until the next completion
//   cout   carry out; for subtraction 1 = no borrow (a >= b unsigned)
//   ovf    signed two's-complement overflow
//
// Optional build macro SATURATE_EN: clamps s to the signed max/min on overflow.
// With the macro defined, cout and ovf still describe the unclamped result.
module chunked_addsub #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q;
    logic [WIDTH-1:0] a_sh_q, b_sh_q, acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;
    logic             a_msb_q, b_msb_q;
    logic [WIDTH-1:0] s_q;
    logic             cout_q, ovf_q;

    logic [CHUNK:0]   sum;
    logic [WIDTH-1:0] r_ext;
    logic [WIDTH-1:0] acc_next;
    logic             last;
    logic             ovf_next;
    logic [WIDTH-1:0] s_next;

    always_comb begin
        sum      = {1'b0, a_sh_q[CHUNK-1:0]} + {1'b0, b_sh_q[CHUNK-1:0]}
                 + {{CHUNK{1'b0}}, carry_q};
        r_ext    = WIDTH'(sum[CHUNK-1:0]);
        // The new chunk enters the accumulator at its top bits. After NCHUNK shifts,
        // the first chunk is in the LSBs.
        acc_next = (acc_q >> CHUNK) | (r_ext << (WIDTH - CHUNK));
        last     = (cnt_q == CW'(NCHUNK - 1));
        // Overflow: the operands have equal signs and the result sign differs.
        ovf_next = (a_msb_q == b_msb_q) && (acc_next[WIDTH-1] != a_msb_q);
`ifdef SATURATE_EN
        if (ovf_next) begin
            s_next = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            s_next = acc_next;
        end
`else
        s_next   = acc_next;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            a_msb_q <= 1'b0;
            b_msb_q <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        // Subtraction is a + ~b + 1; the +1 is the initial carry.
                        a_sh_q  <= a;
                        b_sh_q  <= sub ? ~b : b;
                        acc_q   <= '0;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        a_msb_q <= a[WIDTH-1];
                        b_msb_q <= sub ? ~b[WIDTH-1] : b[WIDTH-1];
                        state_q <= S_RUN;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_RUN: begin
                    a_sh_q  <= a_sh_q >> CHUNK;
                    b_sh_q  <= b_sh_q >> CHUNK;
                    acc_q   <= acc_next;
                    carry_q <= sum[CHUNK];
                    cnt_q   <= cnt_q + CW'(1);
                    if (last) begin
                        s_q     <= s_next;
                        cout_q  <= sum[CHUNK];
                        ovf_q   <= ovf_next;
                        state_q <= S_DONE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);
    assign s    = s_q;
    assign cout = cout_q;
    assign ovf  = ovf_q;

endmodule
